// File: rtl/motorb_dense_serial_config6.sv
// Serial fully-connected layer: buffers an N_IN input vector, streams weights/biases
// from a synchronous ROM with one MAC per cycle, and presents N_OUT Q8.24 results in parallel.
module motorb_dense_serial_config6 #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 9,
  parameter int DW    = 32,
  parameter int FRAC  = 24,
  parameter int ACC_W = 72,
  parameter int AW    = 6
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic [DW-1:0]       in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                w_en,
  output logic [AW-1:0]       w_addr,
  input  logic [DW-1:0]       w_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_OUT*DW-1:0] y_out
);

  localparam int TOT = N_OUT * (N_IN + 1);
  localparam int CW  = $clog2(N_IN + 1);
  localparam int JW  = $clog2(N_OUT + 1);
  localparam int SW  = $clog2(TOT + 1);
  localparam int PW  = 2 * DW;
  localparam logic [CW-1:0] LAST_X = CW'(N_IN - 1);
  localparam logic [CW-1:0] LAST_E = CW'(N_IN);
  localparam logic [SW-1:0] LAST_S = SW'(TOT);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUT} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       iss_q, iss_d;
  logic [CW-1:0]       e_q, e_d;
  logic [JW-1:0]       j_q, j_d;
  logic                tag_vld_q, tag_vld_d;
  logic                tag_bias_q, tag_bias_d;
  logic [CW-1:0]       tag_i_q, tag_i_d;
  logic [JW-1:0]       tag_j_q, tag_j_d;

  logic [N_IN*DW-1:0]      x_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [N_OUT*DW-1:0]     y_q;

  logic signed [DW-1:0]    w_s, x_s;
  logic signed [PW-1:0]    w_ext, x_ext, prod;
  logic signed [ACC_W-1:0] acc_nxt;

  // AP_TRN / AP_WRAP: drop fraction LSBs (floor) and keep the low DW bits of the integer part.
  function automatic logic [DW-1:0] trn_wrap(input logic signed [ACC_W-1:0] a);
    return a[FRAC+DW-1:FRAC];
  endfunction

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= S_LOAD;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:    if (in_valid && cnt_q == LAST_X) state_d = S_COMPUTE;
      S_COMPUTE: if (iss_q == LAST_S)             state_d = S_OUT;
      S_OUT:     if (out_ready)                   state_d = S_LOAD;
      default:                                    state_d = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_LOAD);
    out_valid = (state_q == S_OUT);
    w_en      = (state_q == S_COMPUTE) && (iss_q != LAST_S);
    w_addr    = AW'(iss_q);
    y_out     = y_q;
  end

  // Issue side: e_q walks bias(0), w0..w(N_IN-1) for output j_q; the tag trails by one cycle to meet ROM data.
  always_comb begin
    cnt_d      = cnt_q;
    iss_d      = iss_q;
    e_d        = e_q;
    j_d        = j_q;
    tag_vld_d  = w_en;
    tag_bias_d = (e_q == '0);
    tag_i_d    = (e_q == '0) ? '0 : e_q - 1'b1;
    tag_j_d    = j_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid) cnt_d = (cnt_q == LAST_X) ? '0 : cnt_q + 1'b1;
      end
      S_COMPUTE: begin
        iss_d = iss_q + 1'b1;
        if (w_en) begin
          if (e_q == LAST_E) begin
            e_d = '0;
            j_d = j_q + 1'b1;
          end else begin
            e_d = e_q + 1'b1;
          end
        end
        if (iss_q == LAST_S) begin
          iss_d = '0;
          e_d   = '0;
          j_d   = '0;
        end
      end
      S_OUT:   cnt_d = '0;
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q      <= '0;
      iss_q      <= '0;
      e_q        <= '0;
      j_q        <= '0;
      tag_vld_q  <= 1'b0;
      tag_bias_q <= 1'b0;
      tag_i_q    <= '0;
      tag_j_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      iss_q      <= iss_d;
      e_q        <= e_d;
      j_q        <= j_d;
      tag_vld_q  <= tag_vld_d;
      tag_bias_q <= tag_bias_d;
      tag_i_q    <= tag_i_d;
      tag_j_q    <= tag_j_d;
    end
  end

  // Consume side: full-precision Q16.48 product sign-extended into the accumulator.
  always_comb begin
    w_s     = w_data;
    x_s     = x_q[int'(tag_i_q)*DW +: DW];
    w_ext   = PW'(w_s);
    x_ext   = PW'(x_s);
    prod    = w_ext * x_ext;
    acc_nxt = tag_bias_q ? (ACC_W'(w_s) <<< FRAC) : acc_q + ACC_W'(prod);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      x_q   <= '0;
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      if (in_ready && in_valid) x_q[int'(cnt_q)*DW +: DW] <= in_data;
      if (tag_vld_q) begin
        acc_q <= acc_nxt;
        if (!tag_bias_q && tag_i_q == LAST_X)
          y_q[int'(tag_j_q)*DW +: DW] <= trn_wrap(acc_nxt);
      end
    end
  end

endmodule

// File: tb/tb_motorb_dense_serial_config6.sv
// Directed bench for motorb_dense_serial_config6 with a behavioural synchronous ROM.
module tb_motorb_dense_serial_config6;
  localparam int N_IN  = 4;
  localparam int N_OUT = 9;
  localparam int DW    = 32;
  localparam int AW    = 6;

  logic                ap_clk = 1'b0;
  logic                ap_rst_n = 1'b0;
  logic [DW-1:0]       in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                w_en;
  logic [AW-1:0]       w_addr;
  logic [DW-1:0]       w_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [N_OUT*DW-1:0] y_out;

  motorb_dense_serial_config6 dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out)
  );

  always #5 ap_clk = ~ap_clk;

  logic [DW-1:0] rom [64];
  logic [DW-1:0] xv [N_IN];
  logic [DW-1:0] ey [N_OUT];
  int n_chk = 0, n_pass = 0;
  int en_cnt = 0, addr_err = 0, exp_addr = 0;

  always @(posedge ap_clk) begin
    if (w_en) begin
      w_data <= rom[w_addr];
      if (int'(w_addr) != exp_addr) addr_err = addr_err + 1;
      exp_addr = exp_addr + 1;
      en_cnt   = en_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] y_of(input int j);
    return y_out[j*DW +: DW];
  endfunction

  task automatic clear_rom();
    foreach (rom[k]) rom[k] = '0;
  endtask

  task automatic setw(input int j, input int i, input logic [DW-1:0] v);
    rom[j*(N_IN+1)+1+i] = v;
  endtask

  task automatic send(input int gmax);
    int g;
    for (int i = 0; i < N_IN; i++) begin
      g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
      repeat (g) begin
        in_valid = 1'b0; in_data = 32'hDEADBEEF;
        @(posedge ap_clk); #1;
      end
      in_valid = 1'b1; in_data = xv[i];
      @(posedge ap_clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run(input string tag, input int gmax, input bit chk_lat);
    int n;
    en_cnt = 0; addr_err = 0; exp_addr = 0;
    send(gmax);
    n = 0;
    while (!out_valid && n < 300) begin
      @(posedge ap_clk); #1;
      n++;
    end
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (chk_lat) chk({tag, "_latency"}, n, 46);
    chk({tag, "_wen_cycles"}, en_cnt, 45);
    chk({tag, "_addr_seq"}, addr_err, 0);
    for (int j = 0; j < N_OUT; j++)
      chk($sformatf("%s_y%0d", tag, j), y_of(j), ey[j]);
  endtask

  task automatic take(input string tag);
    logic [DW-1:0] y0;
    y0 = y_of(0);
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    chk({tag, "_take_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_take_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_take_yhold"}, y_of(0), y0);
  endtask

  task automatic setup_neg();
    clear_rom();
    for (int j = 0; j < N_OUT; j++) begin
      rom[j*(N_IN+1)] = 32'(j) * 32'h0040_0000;
      for (int i = 0; i < N_IN; i++) setw(j, i, 32'hFF00_0000);
    end
    for (int i = 0; i < N_IN; i++) xv[i] = 32'h0100_0000;
    ey[0] = 32'hFC00_0000; ey[1] = 32'hFC40_0000; ey[2] = 32'hFC80_0000;
    ey[3] = 32'hFCC0_0000; ey[4] = 32'hFD00_0000; ey[5] = 32'hFD40_0000;
    ey[6] = 32'hFD80_0000; ey[7] = 32'hFDC0_0000; ey[8] = 32'hFE00_0000;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_w_en"}, 32'(w_en), 32'd0);
    chk({tag, "_w_addr"}, 32'(w_addr), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_y_nonzero"}, 32'(y_out != '0), 32'd0);
  endtask

  initial begin
    clear_rom();
    #3;
    chk_reset_outputs("rst");
    @(negedge ap_clk); ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // Identity weights: y[j] = x[j%4]
    clear_rom();
    for (int j = 0; j < N_OUT; j++) setw(j, j % 4, 32'h0100_0000);
    xv[0] = 32'h0100_0000; xv[1] = 32'h0200_0000; xv[2] = 32'hFF00_0000; xv[3] = 32'h0080_0000;
    ey[0] = 32'h0100_0000; ey[1] = 32'h0200_0000; ey[2] = 32'hFF00_0000;
    ey[3] = 32'h0080_0000; ey[4] = 32'h0100_0000; ey[5] = 32'h0200_0000;
    ey[6] = 32'hFF00_0000; ey[7] = 32'h0080_0000; ey[8] = 32'h0100_0000;
    run("id", 0, 1'b1);

    // Backpressure with ignored input pulses
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0]; in_data = 32'h7777_7777;
      @(posedge ap_clk); #1;
      chk($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d_y2", c), y_of(2), 32'hFF00_0000);
    end
    in_valid = 1'b0;
    take("id");

    run("gap", 3, 1'b0);
    take("gap");

    setup_neg();
    run("neg", 0, 1'b1);
    take("neg");

    clear_rom();
    setw(0, 0, 32'h00FF_FFFF);
    xv[0] = 32'h0000_0001; xv[1] = '0; xv[2] = '0; xv[3] = '0;
    foreach (ey[j]) ey[j] = '0;
    run("trnp", 0, 1'b0);
    take("trnp");

    setw(0, 0, 32'hFF00_0001);
    ey[0] = 32'hFFFF_FFFF;
    run("trnn", 0, 1'b0);
    take("trnn");

    clear_rom();
    setw(0, 0, 32'h0100_0000); setw(0, 1, 32'h0100_0000);
    xv[0] = 32'h4000_0000; xv[1] = 32'h4000_0000; xv[2] = '0; xv[3] = '0;
    foreach (ey[j]) ey[j] = '0;
    ey[0] = 32'h8000_0000;
    run("wrap", 0, 1'b0);
    take("wrap");

    // Abort mid-COMPUTE, then a clean run
    setup_neg();
    send(0);
    repeat (20) @(posedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(negedge ap_clk); ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    run("post", 0, 1'b1);
    take("post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
